// File: rtl/mem_stream_pkg.sv
// Shared types for the memory-to-stream reader: controller states and the
// depth of the skid FIFO between the memory port and the output stream.
package mem_stream_pkg;

  localparam int unsigned FifoDepth = 2;
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);

  typedef logic [CntW-1:0] fifo_cnt_t;

  localparam fifo_cnt_t FifoFull = fifo_cnt_t'(FifoDepth);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/std_mem_d1_reader_if.sv
// Memory port plus output ready/valid stream of the reader; master is the
// reader, slave is the memory-and-consumer side.
interface std_mem_d1_reader_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_SIZE = 4
);
  logic [IDX_SIZE-1:0] addr0;
  logic                write_en;
  logic [WIDTH-1:0]    write_data;
  logic [WIDTH-1:0]    read_data;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output addr0, write_en, write_data, out_data, out_valid,
    input  read_data, out_ready
  );

  modport slave (
    input  addr0, write_en, write_data, out_data, out_valid,
    output read_data, out_ready
  );
endinterface

// File: rtl/mem_stream_fifo2.sv
// Two-entry FIFO with registered head/tail; a full FIFO still accepts a push
// when a pop happens in the same cycle. Synchronous flush on reset.
module mem_stream_fifo2
  import mem_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output fifo_cnt_t        count
);

  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  fifo_cnt_t        count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q < FifoFull) || do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == '0) head_d = push_data;
        else               tail_d = push_data;
        count_d = count_q + 1'b1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 1'b1;
      end
      2'b11: begin
        // Count is unchanged; the new word lands behind whatever stays queued.
        if (count_q == fifo_cnt_t'(1)) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/std_mem_d1_reader.sv
// Drains base..base+len-1 of a std_mem_d1 memory into a ready/valid stream,
// one word per cycle when unstalled, with a go/done control handshake.
module std_mem_d1_reader
  import mem_stream_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 16,
  parameter int unsigned IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE-1:0] base,
  input  logic [IDX_SIZE:0]   len,
  output logic                done,
  output logic                busy,
  std_mem_d1_reader_if.master bus
);

  localparam logic [IDX_SIZE:0] SizeW = (IDX_SIZE + 1)'(SIZE);

  state_e              state_q, state_d;
  // One extra bit so running past the top of memory stays visible to the
  // bounds check; addr0 drops it, so the memory port wraps mod 2^IDX_SIZE.
  logic [IDX_SIZE:0]   addr_q, addr_d;
  logic [IDX_SIZE:0]   remaining_q, remaining_d;
  logic [IDX_SIZE-1:0] addr0;
  logic                push, pop;
  fifo_cnt_t           count;
  logic [WIDTH-1:0]    head;

  assign pop = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    push        = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    addr0       = '0;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (go) begin
          addr_d      = {1'b0, base};
          remaining_d = len;
          state_d     = (len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        addr0 = addr_q[IDX_SIZE-1:0];
        // Registered count only: keeps out_ready off the addr0 path.
        push  = (count < FifoFull);
        if (push) begin
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (IDX_SIZE + 1)'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (count == '0 || (count == fifo_cnt_t'(1) && pop)) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  mem_stream_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(bus.read_data),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign bus.addr0      = addr0;
  assign bus.write_en   = 1'b0;
  assign bus.write_data = '0;
  assign bus.out_valid  = (count != '0);
  assign bus.out_data   = head;

  always_ff @(posedge clk) begin
    if (!reset && state_q == StRun && addr_q >= SizeW) begin
      $error("std_mem_d1_reader: Out of bounds access\naddr0: %0d\nSIZE: %0d", addr_q, SIZE);
    end
  end

endmodule

// File: doc/std_mem_d1_reader.md
# std_mem_d1_reader

Sequential reader that drains a contiguous range of a `std_mem_d1`-compatible memory and presents the words as a ready/valid stream. It drives the memory's `addr0`/`write_en`/`write_data` ports, samples the combinational `read_data`, and buffers words in a 2-entry FIFO so it sustains one word per cycle under no backpressure. Control follows the Calyx `go`/`done` convention, so a compiled component can invoke it like any other cell.

## Interface
- `WIDTH`, 32, data word width; matches the memory's `WIDTH`.
- `SIZE`, 16, memory depth in words.
- `IDX_SIZE`, 4, memory address width.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `go` input 1: start request, sampled only in IDLE.
- `base` input IDX_SIZE: first word address, latched on accepted `go`.
- `len` input IDX_SIZE+1: word count (0..SIZE), latched on accepted `go`.
- `done` output 1: one-cycle completion pulse.
- `busy` output 1: high in every state except IDLE.
- `addr0` output IDX_SIZE: memory address.
- `write_data` output WIDTH: constant 0.
- `write_en` output 1: constant 0. The reader never writes.
- `read_data` input WIDTH: memory combinational read data.
- `out_data` output WIDTH: stream data (FIFO head).
- `out_valid` output 1: stream valid.
- `out_ready` input 1: stream ready.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE with `go`=1: latch `base` into `addr_q`, latch `len` into `remaining`.
  - If `len`=0, go to DONE.
  - Otherwise go to RUN.
- RUN:
  - `addr0` = `addr_q`.
  - push = (FIFO count < 2). On push, enqueue `read_data`, increment `addr_q` modulo 2^IDX_SIZE, and decrement `remaining`.
  - A push with `remaining`=1 moves to DRAIN.
  - Push eligibility uses registered count only, so there is no combinational `out_ready`→`addr0` path.
- DRAIN: no pushes. Exit to DONE when count=0, or when count=1 and a pop occurs this cycle.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally. `go` is ignored in DONE.
- Pop = `out_valid` && `out_ready`.
- `out_valid` = (count≠0). `out_data` = FIFO head.
- While `out_valid` && !`out_ready`, `out_data` must be held stable.
- Push and pop in the same cycle with count=1: count stays 1 and ordering is preserved.
- Stream order equals address order. No word is dropped or duplicated.
- Out of bounds: a RUN cycle with `addr_q` ≥ SIZE raises a simulation `$error` under VERILATOR, with the same message style as the memory's own check. The hardware still wraps.
- Reset, including mid-operation:
  - State returns to IDLE and the FIFO is flushed.
  - `done`=0, `busy`=0, `out_valid`=0, `addr0`=0, `out_data`=0.
  - `write_en` and `write_data` are always 0.

## Timing
- `go` accepted at edge of cycle 0. RUN spans cycle 1 onward, with `addr0`=`base` in cycle 1.
- First `out_valid` appears in cycle 2.
- Without stalls:
  - word k is valid in cycle k+2;
  - `done` pulses in cycle `len`+2;
  - `busy` is high in cycles 1..`len`+2.
- `len`=0: `done` in cycle 1, with no `out_valid` and no memory access.
- Each stall cycle with a full FIFO delays all later events by one cycle.
- `done` is asserted only after the last word has been accepted downstream.

## Structure
- Package `mem_stream_pkg`: state enum typedef (IDLE/RUN/DRAIN/DONE) and the FIFO depth constant (2).
- Sub-module `mem_stream_fifo2`, parameterised by WIDTH:
  - ports: `clk`, `reset`, `push`, `push_data`, `pop`, `head`, `count`;
  - registered storage;
  - synchronous flush on reset.
- Top-level register set: `state`, `addr_q`, and `remaining` (width IDX_SIZE+1).

## Test plan
- Memory word i = 3·i, `base`=2, `len`=4, `out_ready`=1 → `out_data` is 6, 9, 12, 15 in cycles 2–5, and `done` pulses in cycle 6 only.
- `len`=0 → `done` in cycle 1, `out_valid` never high, `addr0` held at 0.
- `base`=0, `len`=6, `out_ready`=0 in cycles 2–6 → FIFO holds 2 words, `addr0` frozen at 2, `out_data`=0 stable throughout. After release, the sequence 0, 3, 6, 9, 12, 15 arrives with no gap or duplicate.
- `base`=14, `len`=2 (SIZE=16) → 42, 45 with no error. `base`=15, `len`=2 → `$error` fires when `addr_q`=16 wraps to 0.
- `len`=8, `reset` asserted in cycle 3 → cycle 4 shows `out_valid`=0, `busy`=0, `done`=0. A new `go` in cycle 5 with `base`=0, `len`=1 yields 0 and then `done`.
- Random `out_ready` over 200 transactions with `go` held high through DONE → every transaction's stream matches memory contents in order, and `done` never exceeds one cycle.
